step_counter: RTL and testbench

//   Parametrised signed-step up/down counter; successor to the 2-bit-ctrl fixed-width counter.

---
 rtl/step_counter_pkg.sv | 7 +
 rtl/step_counter_next.sv | 34 +++
 rtl/step_counter.sv | 61 ++++++
 tb/tb_step_counter.sv | 100 ++++++++++
 4 files changed

// File: rtl/step_counter_pkg.sv
// step_counter_pkg: shared step encoding and flag bit positions for step_counter
package step_counter_pkg;
  localparam int STEP_HOLD = 0;
  localparam int FLAG_OVF = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_W = 2;
endpackage

// File: rtl/step_counter_next.sv
// step_counter_next: next-count and flag logic; ports cnt/ctrl/sat/lo/hi in, nxt/ovf_nxt/unf_nxt out
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int N = 4,
  parameter int Nc = 2
) (
  input  logic [N-1:0]  cnt,
  input  logic [Nc-1:0] ctrl,
  input  logic          sat,
  input  logic [N-1:0]  lo,
  input  logic [N-1:0]  hi,
  output logic [N-1:0]  nxt,
  output logic          ovf_nxt,
  output logic          unf_nxt
);
  localparam int W = N + 2;
  localparam logic signed [W-1:0] ONE = 1;
  logic signed [W-1:0] sum, lo_s, hi_s, wo, wu;
  logic hold;
  assign lo_s = signed'({2'b00, lo});
  assign hi_s = signed'({2'b00, hi});
  assign sum = signed'({2'b00, cnt}) + W'(signed'(ctrl));
  assign hold = ctrl == Nc'(STEP_HOLD);
  assign ovf_nxt = !hold && sum > hi_s;
  assign unf_nxt = !hold && sum < lo_s;
  // A wrap can still land outside a range narrower than the step; clamp then.
  assign wo = lo_s + sum - hi_s - ONE;
  assign wu = hi_s - lo_s + sum + ONE;
  always_comb
    nxt = ovf_nxt ? ((sat || wo > hi_s) ? hi : wo[N-1:0]) :
          unf_nxt ? ((sat || wu < lo_s) ? lo : wu[N-1:0]) :
          hold    ? cnt : sum[N-1:0];
endmodule

// File: rtl/step_counter.sv
// step_counter: signed-step up/down counter, wrap/saturate, load, registered ovf/unf; ports clk rst_n en ctrl sat ld ld_val [lim_lo lim_hi with STEP_COUNTER_BOUNDS_EN] out ovf unf at_lo at_hi
module step_counter
  import step_counter_pkg::*;
#(
  parameter int N = 4,
  parameter int Nc = 2,
  parameter int RST_VAL = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [Nc-1:0] ctrl,
  input  logic          sat,
  input  logic          ld,
  input  logic [N-1:0]  ld_val,
`ifdef STEP_COUNTER_BOUNDS_EN
  input  logic [N-1:0]  lim_lo,
  input  logic [N-1:0]  lim_hi,
`endif
  output logic [N-1:0]  out,
  output logic          ovf,
  output logic          unf,
  output logic          at_lo,
  output logic          at_hi
);
  logic [N-1:0] lo, hi, nxt;
  logic ovf_nxt, unf_nxt;
  logic [FLAG_W-1:0] flg, flg_nxt;
`ifdef STEP_COUNTER_BOUNDS_EN
  assign lo = lim_lo;
  assign hi = lim_hi;
`else
  assign lo = '0;
  assign hi = '1;
`endif
  step_counter_next #(.N(N), .Nc(Nc)) u_next (
    .cnt(out), .ctrl(ctrl), .sat(sat), .lo(lo), .hi(hi),
    .nxt(nxt), .ovf_nxt(ovf_nxt), .unf_nxt(unf_nxt)
  );
  always_comb begin
    flg_nxt = '0;
    flg_nxt[FLAG_OVF] = ovf_nxt;
    flg_nxt[FLAG_UNF] = unf_nxt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out <= N'(RST_VAL);
      flg <= '0;
    end else if (ld) begin
      out <= ld_val;
      flg <= '0;
    end else if (en) begin
      out <= nxt;
      flg <= flg_nxt;
    end else
      flg <= '0;
  assign ovf = flg[FLAG_OVF];
  assign unf = flg[FLAG_UNF];
  assign at_lo = out == lo;
  assign at_hi = out == hi;
endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: scoreboard bench for step_counter (N=4, Nc=2)
module tb_step_counter;
  typedef struct packed {
    logic [3:0] o;
    logic v, u, l, h;
  } exp_t;
  logic clk = 0, rst_n = 0, en = 0, sat = 0, ld = 0;
  logic [1:0] ctrl = 0;
  logic [3:0] ld_val = 0, cnt, lo_m = 0, hi_m = 15;
  logic ovf, unf, at_lo, at_hi;
  exp_t q[$];
  int n_vec = 0, n_err = 0;
`ifdef STEP_COUNTER_BOUNDS_EN
  logic [3:0] lim_lo = 0, lim_hi = 15;
`endif
  step_counter #(.N(4), .Nc(2), .RST_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ctrl(ctrl), .sat(sat), .ld(ld), .ld_val(ld_val),
`ifdef STEP_COUNTER_BOUNDS_EN
    .lim_lo(lim_lo), .lim_hi(lim_hi),
`endif
    .out(cnt), .ovf(ovf), .unf(unf), .at_lo(at_lo), .at_hi(at_hi)
  );
  always #10 clk = ~clk;
  function automatic exp_t mk(input logic [3:0] o, input logic v, input logic u);
    mk = '{o: o, v: v, u: u, l: o == lo_m, h: o == hi_m};
  endfunction
  task automatic cmp(input string nm, input exp_t e);
    exp_t a;
    a = '{o: cnt, v: ovf, u: unf, l: at_lo, h: at_hi};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got out=%0d ovf=%b unf=%b at_lo=%b at_hi=%b, want out=%0d ovf=%b unf=%b at_lo=%b at_hi=%b",
               nm, a.o, a.v, a.u, a.l, a.h, e.o, e.v, e.u, e.l, e.h);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) cmp("edge", q.pop_front());
  end
  task automatic cyc(input logic e, input logic [1:0] c, input logic s, input logic l,
                     input logic [3:0] lv, input logic [3:0] o, input logic v, input logic u);
    @(negedge clk);
    en = e; ctrl = c; sat = s; ld = l; ld_val = lv;
`ifdef STEP_COUNTER_BOUNDS_EN
    lim_lo = lo_m; lim_hi = hi_m;
`endif
    q.push_back(mk(o, v, u));
  endtask
  initial begin
    #15;
    cmp("reset", mk(4'd0, 0, 0));
    @(negedge clk) rst_n = 1;
    for (int i = 1; i <= 20; i++) cyc(1, 2'b01, 0, 0, 0, 4'(i % 16), i == 16, 0);
    cyc(0, 2'b01, 1, 1, 14, 14, 0, 0);
    cyc(1, 2'b01, 1, 0, 0, 15, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2'b01, 1, 0, 0, 15, 1, 0);
    cyc(0, 2'b00, 0, 1, 1, 1, 0, 0);
    cyc(1, 2'b10, 0, 0, 0, 15, 0, 1);
    cyc(1, 2'b10, 0, 0, 0, 13, 0, 0);
    cyc(0, 2'b00, 1, 1, 1, 1, 0, 0);
    cyc(1, 2'b10, 1, 0, 0, 0, 0, 1);
    cyc(1, 2'b10, 1, 0, 0, 0, 0, 1);
    cyc(0, 2'b00, 0, 1, 5, 5, 0, 0);
    cyc(1, 2'b11, 0, 0, 0, 4, 0, 0);
    cyc(0, 2'b11, 0, 0, 0, 4, 0, 0);
    cyc(1, 2'b11, 0, 0, 0, 3, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 3, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 3, 0, 0);
    cyc(0, 2'b00, 0, 1, 8, 8, 0, 0);
    cyc(1, 2'b01, 0, 0, 0, 9, 0, 0);
    @(posedge clk);
    #5 rst_n = 0;
    #1 cmp("mid_reset", mk(4'd0, 0, 0));
    @(negedge clk) rst_n = 1;
    cyc(1, 2'b01, 0, 1, 7, 7, 0, 0);
    cyc(1, 2'b01, 0, 0, 0, 8, 0, 0);
`ifdef STEP_COUNTER_BOUNDS_EN
    lo_m = 3; hi_m = 10;
    cyc(0, 2'b00, 0, 1, 9, 9, 0, 0);
    cyc(1, 2'b01, 0, 0, 0, 10, 0, 0);
    cyc(1, 2'b01, 0, 0, 0, 3, 1, 0);
    cyc(0, 2'b00, 0, 1, 4, 4, 0, 0);
    cyc(1, 2'b10, 0, 0, 0, 10, 0, 1);
    lo_m = 5; hi_m = 5;
    cyc(0, 2'b00, 0, 1, 3, 3, 0, 0);
    cyc(1, 2'b01, 0, 0, 0, 5, 0, 1);
    cyc(1, 2'b01, 0, 0, 0, 5, 1, 0);
`endif
    @(negedge clk) en = 0; ld = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
